uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line between the DRAM-controller console and the CPU UART,
// handing ownership over only on frame boundaries with a one-bit guard gap.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 108,
  parameter int unsigned IDLE_BITS    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_init_done,
  input  logic       i_init_error,
  input  logic       i_src0_tx,
  input  logic       i_src1_tx,
  input  logic       i_ovr_en,
  input  logic       i_ovr_sel,
  output logic       o_uart_tx,
  output logic       o_sel,
  output logic       o_busy,
  output logic [7:0] o_drop_cnt
);

  localparam int unsigned T  = CLKS_PER_BIT * IDLE_BITS;
  localparam int unsigned CW = $clog2(T + 1);
  localparam int unsigned GW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] T_V    = CW'(T);
  localparam logic [GW-1:0] G_LAST = GW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_DRAIN, ST_GUARD} state_t;

  state_t               state_q, state_d;
  logic [1:0]           meta_q, meta_d, sync_q, sync_d, sync_dly_q, sync_dly_d;
  logic [1:0][CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [1:0]           idle_q, idle_d, idle;
  logic [GW-1:0]        guard_q, guard_d;
  logic                 sel_q, sel_d, tx_q, tx_d, busy_q, busy_d;
  logic [7:0]           drop_q, drop_d;
  logic [8:0]           drop_sum;
  logic [1:0]           fall, driving, drop_ev;
  logic                 desired, owning;

  always_comb begin
    meta_d     = {i_src1_tx, i_src0_tx};
    sync_d     = meta_q;
    sync_dly_d = sync_q;

    // The idle flag is registered and re-qualified with the live sync bit so a
    // start bit already visible in sync_q always blocks a handover.
    for (int unsigned n = 0; n < 2; n++) begin
      if (!sync_q[n])
        idle_cnt_d[n] = '0;
      else if (idle_cnt_q[n] != T_V)
        idle_cnt_d[n] = idle_cnt_q[n] + CW'(1);
      else
        idle_cnt_d[n] = idle_cnt_q[n];
      idle_d[n] = sync_q[n] && (idle_cnt_q[n] == T_V);
    end
    idle = idle_q & sync_q;

    if (i_ovr_en)          desired = i_ovr_sel;
    else if (i_init_error) desired = 1'b0;
    else if (i_init_done)  desired = 1'b1;
    else                   desired = 1'b0;

    state_d = state_q;
    sel_d   = sel_q;
    guard_d = guard_q;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (idle[desired]) begin
          state_d = ST_OWN;
          sel_d   = desired;
        end
      end
      ST_OWN: begin
        tx_d = sync_q[sel_q];
        if (desired != sel_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        tx_d = sync_q[sel_q];
        if (desired == sel_q) begin
          state_d = ST_OWN;
        end else if (idle[sel_q] && idle[desired]) begin
          state_d = ST_GUARD;
          sel_d   = desired;
          guard_d = '0;
        end
      end
      ST_GUARD: begin
        if (guard_q == G_LAST) state_d = ST_OWN;
        else                   guard_d = guard_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_OWN);

    owning     = (state_q == ST_OWN) || (state_q == ST_DRAIN);
    driving[0] = owning && !sel_q;
    driving[1] = owning && sel_q;
    fall       = sync_dly_q & ~sync_q;
    drop_ev    = fall & ~driving;
    drop_sum   = {1'b0, drop_q} + {8'd0, drop_ev[0]} + {8'd0, drop_ev[1]};
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      meta_q     <= '1;
      sync_q     <= '1;
      sync_dly_q <= '1;
      idle_cnt_q <= '0;
      idle_q     <= '0;
      guard_q    <= '0;
      sel_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b1;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
      guard_q    <= guard_d;
      sel_q      <= sel_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign o_uart_tx  = tx_q;
  assign o_sel      = sel_q;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule
